tabla_sweep_ctrl: RTL and testbench
===================================

# tabla_sweep_ctrl

Sequencer and scheduler for the lab's mux-based truth-table units (8:1, 4:1 and 2:1 implementations of the same 3-input function). It time-shares a single external result line among the three implementations. For each implementation it sweeps the inputs ABC from 000 to 111 and captures each output bit into a per-implementation 8-bit truth-table register. When the sweep finishes, it reports per-implementation match against an expected table and whether all three implementations agree. It replaces the hand-written `#1` stimulus sequences with a synthesizable, clocked controller.

## Interface
- SETTLE, 2: number of cycles the output waits after `abc`/`impl_sel` change before `y_in` is sampled. Legal range is 0..15.
- EXPECTED, 8'h96: expected truth table. Bit n is Y for ABC = n. The default is 3-input XOR.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a full sweep. Sampled only in IDLE.
- y_in  in  1  output of the implementation currently selected by `impl_sel` (external 3:1 mux).
- abc  out  3  ABC stimulus, driven to all three implementations. Mux8 select = abc. Mux4 select = abc[2:1], C = abc[0]. Mux2 select = abc[2], B = abc[1], C = abc[0].
- impl_sel  out  2  0 = mux8, 1 = mux4, 2 = mux2. The value 3 is never driven.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- tt0, tt1, tt2  out  8 each  captured truth tables.
- match  out  3  match[i] = valid & (tt_i == EXPECTED).
- agree  out  1  valid & (tt0 == tt1) & (tt1 == tt2).

## Operation
- States: IDLE, RUN, DONE.
- IDLE, when start = 1:
  - abc <= 0, impl_sel <= 0, cnt <= 0.
  - tt0/tt1/tt2 <= 0, valid <= 0.
  - busy <= 1, go to RUN.
- IDLE, when start = 0: all registers hold.
- RUN, when cnt < SETTLE: cnt++.
- RUN, when cnt == SETTLE:
  - tt[impl_sel][abc] <= y_in, cnt <= 0.
  - If impl_sel == 2 and abc == 7: go to DONE.
  - Else if abc == 7: abc <= 0, impl_sel++.
  - Else: abc++.
- Sweep order is implementation-major, ABC-minor: (0,000)…(0,111), (1,000)…(2,111). That is 24 points in total.
- DONE (one cycle): done = 1, busy = 0, valid = 1. Go to IDLE.
- `abc` and `impl_sel` hold their last values (7, 2) after the sweep.
- `match` and `agree` are combinational from the tt registers, gated by `valid`.
  - `valid` is cleared by the next accepted start or by reset.
  - The results therefore stay readable until the next sweep.
- `start` is ignored in RUN and DONE. Requests arriving then are not queued.
- A `start` held high continuously is accepted in the IDLE cycle that follows DONE. This gives back-to-back sweeps separated by one IDLE cycle.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - abc = 0, impl_sel = 0, cnt = 0.
  - busy = 0, done = 0, valid = 0.
  - tt0 = tt1 = tt2 = 0, so match = 0 and agree = 0.
- Reset mid-sweep aborts it. There is no partial result, and the next start runs a full sweep.
- If start is accepted at edge k:
  - busy = 1 after edge k.
  - Point p = 8·impl + abc is driven after edge k + p·(SETTLE+1).
  - Point p is sampled at edge k + (p+1)·(SETTLE+1).
- Each point is held stable for exactly SETTLE+1 cycles. `y_in` must be valid by the last of those cycles.
- The last sample is at edge k + 24·(SETTLE+1). done = 1, busy = 0 and valid = 1 after that edge, for one cycle.
  - SETTLE = 2: done follows edge k+72.
  - SETTLE = 0: done follows edge k+24, and `abc` changes every cycle.
- `done` and `busy` are never high together.

## Test plan
- Reset: hold rst_n = 0 with random start/y_in, then release → all outputs 0, and busy stays 0 while start = 0.
- Golden sweep (SETTLE = 2, bench drives y_in = ^abc for every impl_sel), pulse start → abc sequence 0..7 repeated three times, each value held 3 cycles; done is a single pulse 72 edges after the start edge; tt0 = tt1 = tt2 = 8'h96, match = 3'b111, agree = 1.
- Faulty implementation: invert y_in only for impl_sel = 1, abc = 5 → tt1 = 8'hB6, tt0 = tt2 = 8'h96, match = 3'b101, agree = 0; values hold until the next start.
- Start handling: extra start pulses during RUN and on the DONE cycle → exactly one done, still at +72. Start held high → second sweep begins on the IDLE cycle after DONE; valid and match drop to 0 at that edge.
- Reset mid-sweep: assert rst_n = 0 at point (impl 1, abc 3) → outputs 0 immediately; a new start completes a full 72-cycle sweep with correct results.
- SETTLE = 0 instance → done 24 edges after start; `abc` increments every cycle; golden results are identical to the golden-sweep scenario.

Source files
------------

// File: rtl/tabla_sweep_ctrl.sv
// Sweep sequencer for the three mux-based truth-table units: drives ABC for each
// implementation in turn, captures y_in after SETTLE cycles, and reports match/agree.
module tabla_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'h96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic [2:0] abc,
  output logic [1:0] impl_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt0,
  output logic [7:0] tt1,
  output logic [7:0] tt2,
  output logic [2:0] match,
  output logic       agree
);
  localparam int unsigned NUM_IMPL = 3;
  localparam logic [3:0]  SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  abc_q, abc_d;
  logic [1:0]                  sel_q, sel_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [NUM_IMPL-1:0][7:0]    tt_q, tt_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  always_comb begin
    state_d = state_q;
    abc_d   = abc_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        abc_d   = '0;
        sel_d   = '0;
        cnt_d   = '0;
        tt_d    = '0;
        valid_d = 1'b0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q < SETTLE_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = '0;
          for (int i = 0; i < NUM_IMPL; i++)
            if (sel_q == 2'(i)) tt_d[i][abc_q] = y_in;
          if (sel_q == 2'd2 && abc_q == 3'd7) begin
            // abc/impl_sel deliberately stay at (7,2) after the last point
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else if (abc_q == 3'd7) begin
            abc_d = '0;
            sel_d = sel_q + 2'd1;
          end else begin
            abc_d = abc_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      abc_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_IMPL; i++) begin : g_match
    assign match[i] = valid_q & (tt_q[i] == EXPECTED);
  end

  assign agree    = valid_q & (tt_q[0] == tt_q[1]) & (tt_q[1] == tt_q[2]);
  assign abc      = abc_q;
  assign impl_sel = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt0      = tt_q[0];
  assign tt1      = tt_q[1];
  assign tt2      = tt_q[2];
endmodule

// File: tb/tb_tabla_sweep_ctrl.sv
// Bench for tabla_sweep_ctrl: SETTLE=2 and SETTLE=0 instances, external units modelled
// as 3-input XOR with a per-point inversion mask.
module tb_tabla_sweep_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        start_a = 0, start_b = 0;
  logic        yr_en = 1, yr = 0;
  logic [31:0] fmask = '0;
  int          errs = 0, checks = 0;

  logic [2:0] abc_a, abc_b, match_a, match_b;
  logic [1:0] impl_a, impl_b;
  logic       busy_a, busy_b, done_a, done_b, agree_a, agree_b, y_a, y_b;
  logic [7:0] tt0_a, tt1_a, tt2_a, tt0_b, tt1_b, tt2_b;

  always #5 clk = ~clk;

  assign y_a = yr_en ? yr : ((^abc_a) ^ fmask[{impl_a, abc_a}]);
  assign y_b = yr_en ? yr : ((^abc_b) ^ fmask[{impl_b, abc_b}]);

  tabla_sweep_ctrl #(.SETTLE(2), .EXPECTED(8'h96)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_in(y_a), .abc(abc_a), .impl_sel(impl_a),
    .busy(busy_a), .done(done_a), .tt0(tt0_a), .tt1(tt1_a), .tt2(tt2_a),
    .match(match_a), .agree(agree_a));

  tabla_sweep_ctrl #(.SETTLE(0), .EXPECTED(8'h96)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_in(y_b), .abc(abc_b), .impl_sel(impl_b),
    .busy(busy_b), .done(done_b), .tt0(tt0_b), .tt1(tt1_b), .tt2(tt2_b),
    .match(match_b), .agree(agree_b));

  // Reference truth table of impl i: XOR of the three input bits, flipped where the mask says.
  function automatic logic [7:0] exp_tt(input int i, input logic [31:0] m);
    logic [7:0] r;
    for (int n = 0; n < 8; n++) r[n] = (((n >> 2) ^ (n >> 1) ^ n) & 1) ^ m[8*i+n];
    return r;
  endfunction

  function automatic logic [2:0] exp_match(input logic [31:0] m);
    return {exp_tt(2, m) == 8'h96, exp_tt(1, m) == 8'h96, exp_tt(0, m) == 8'h96};
  endfunction

  function automatic logic exp_agree(input logic [31:0] m);
    return (exp_tt(0, m) == exp_tt(1, m)) && (exp_tt(1, m) == exp_tt(2, m));
  endfunction

  // Pulses (or holds) start, watches the whole sweep; seq_ok covers abc/impl/busy order.
  task automatic sweep(input int sel, input bit hold, input bit noise,
                       output int lat, output int ndone, output bit seq_ok);
    int per, tot, p;
    logic [2:0] a; logic [1:0] im; logic bz, dn;
    per = (sel == 0) ? 3 : 1;
    tot = 24 * per;
    lat = -1; ndone = 0; seq_ok = 1;
    if (sel == 0) start_a = 1; else start_b = 1;
    @(posedge clk); #1;
    if (!hold) begin
      if (sel == 0) start_a = 0; else start_b = 0;
    end
    for (int c = 0; c <= tot + 1; c++) begin
      a  = sel ? abc_b  : abc_a;
      im = sel ? impl_b : impl_a;
      bz = sel ? busy_b : busy_a;
      dn = sel ? done_b : done_a;
      if (c < tot) begin
        p = c / per;
        if (a != 3'(p % 8) || im != 2'(p / 8) || !bz) seq_ok = 0;
      end
      if (dn) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (dn && bz) seq_ok = 0;
      if (noise && !hold) begin
        if (sel == 0) start_a = (c <= tot) ? 1'($urandom_range(0, 1)) : 1'b0;
        else          start_b = (c <= tot) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (c <= tot) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; yr_en = 1;
    repeat (5) begin
      yr = 1'($urandom); start_a = 1'($urandom); start_b = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if ({abc_a, impl_a, busy_a, done_a, tt0_a, tt1_a, tt2_a, match_a, agree_a} !== '0) begin
      errs++; $display("FAIL reset_a: got abc=%0d impl=%0d busy=%b tt=%h/%h/%h match=%b agree=%b want all 0",
                       abc_a, impl_a, busy_a, tt0_a, tt1_a, tt2_a, match_a, agree_a);
    end
    checks++;
    if ({abc_b, impl_b, busy_b, done_b, tt0_b, tt1_b, tt2_b, match_b, agree_b} !== '0) begin
      errs++; $display("FAIL reset_b: outputs not all 0");
    end
    start_a = 0; start_b = 0; yr_en = 0; rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
        errs++; $display("FAIL idle_busy: got %b/%b want 0/0", busy_a, busy_b);
      end
    end
  endtask

  task automatic test_golden();
    int lat, nd; bit ok;
    fmask = '0;
    sweep(0, 0, 0, lat, nd, ok);
    checks++; if (lat !== 72 || nd !== 1) begin errs++; $display("FAIL golden_done: lat=%0d n=%0d want 72/1", lat, nd); end
    checks++; if (!ok) begin errs++; $display("FAIL golden_seq: got bad sequence want 0..7 x3 held 3"); end
    checks++;
    if ({tt0_a, tt1_a, tt2_a} !== {3{8'h96}}) begin
      errs++; $display("FAIL golden_tt: got %h/%h/%h want 96/96/96", tt0_a, tt1_a, tt2_a);
    end
    checks++;
    if (match_a !== 3'b111 || agree_a !== 1'b1) begin
      errs++; $display("FAIL golden_match: got %b/%b want 111/1", match_a, agree_a);
    end
  endtask

  task automatic test_fault();
    int lat, nd; bit ok;
    fmask = 32'h1 << 13;
    sweep(0, 0, 0, lat, nd, ok);
    checks++;
    if ({tt0_a, tt1_a, tt2_a} !== {8'h96, 8'hB6, 8'h96}) begin
      errs++; $display("FAIL fault_tt: got %h/%h/%h want 96/B6/96", tt0_a, tt1_a, tt2_a);
    end
    checks++;
    if (match_a !== 3'b101 || agree_a !== 1'b0) begin
      errs++; $display("FAIL fault_match: got %b/%b want 101/0", match_a, agree_a);
    end
    repeat (10) @(posedge clk); #1;
    checks++;
    if (tt1_a !== 8'hB6 || match_a !== 3'b101 || agree_a !== 1'b0) begin
      errs++; $display("FAIL fault_hold: got tt1=%h match=%b agree=%b want B6/101/0", tt1_a, match_a, agree_a);
    end
  endtask

  task automatic test_start_handling();
    int lat, nd, w; bit ok;
    fmask = '0;
    sweep(0, 0, 1, lat, nd, ok);
    checks++; if (lat !== 72 || nd !== 1) begin errs++; $display("FAIL noise_done: lat=%0d n=%0d want 72/1", lat, nd); end
    checks++; if (!ok || match_a !== 3'b111) begin errs++; $display("FAIL noise_result: seq=%b match=%b want 1/111", ok, match_a); end
    sweep(0, 1, 0, lat, nd, ok);
    checks++; if (lat !== 72 || nd !== 1 || !ok) begin errs++; $display("FAIL hold_first: lat=%0d n=%0d seq=%b want 72/1/1", lat, nd, ok); end
    checks++; if (match_a !== 3'b111 || busy_a !== 1'b0) begin errs++; $display("FAIL hold_idle: match=%b busy=%b want 111/0", match_a, busy_a); end
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b1 || match_a !== 3'b000 || agree_a !== 1'b0 || tt0_a !== 8'h00) begin
      errs++; $display("FAIL hold_restart: busy=%b match=%b agree=%b tt0=%h want 1/000/0/00", busy_a, match_a, agree_a, tt0_a);
    end
    start_a = 0;
    w = 0;
    while (!done_a && w < 200) begin @(posedge clk); #1; w++; end
    checks++; if (!done_a) begin errs++; $display("FAIL hold_second_done: got no done within 200 want done"); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat, nd; bit ok;
    fmask = '0;
    start_a = 1; @(posedge clk); #1; start_a = 0;
    repeat (33) @(posedge clk); #1;
    checks++; if (abc_a !== 3'd3 || impl_a !== 2'd1) begin errs++; $display("FAIL mid_point: got %0d/%0d want 1/3", impl_a, abc_a); end
    rst_n = 0; #1;
    checks++;
    if ({abc_a, impl_a, busy_a, done_a, tt0_a, tt1_a, tt2_a, match_a, agree_a} !== '0) begin
      errs++; $display("FAIL mid_reset: abc=%0d impl=%0d busy=%b tt0=%h want all 0", abc_a, impl_a, busy_a, tt0_a);
    end
    @(posedge clk); #1; rst_n = 1;
    sweep(0, 0, 0, lat, nd, ok);
    checks++;
    if (lat !== 72 || nd !== 1 || !ok || match_a !== 3'b111 || agree_a !== 1'b1) begin
      errs++; $display("FAIL mid_rerun: lat=%0d n=%0d seq=%b match=%b want 72/1/1/111", lat, nd, ok, match_a);
    end
  endtask

  task automatic test_settle0();
    int lat, nd; bit ok;
    fmask = '0;
    sweep(1, 0, 0, lat, nd, ok);
    checks++; if (lat !== 24 || nd !== 1) begin errs++; $display("FAIL s0_done: lat=%0d n=%0d want 24/1", lat, nd); end
    checks++; if (!ok) begin errs++; $display("FAIL s0_seq: got abc not stepping each cycle want step"); end
    checks++;
    if ({tt0_b, tt1_b, tt2_b} !== {3{8'h96}} || match_b !== 3'b111 || agree_b !== 1'b1) begin
      errs++; $display("FAIL s0_result: got %h/%h/%h %b/%b want 96x3 111/1", tt0_b, tt1_b, tt2_b, match_b, agree_b);
    end
  endtask

  task automatic test_random();
    int lat, nd; bit ok;
    logic [7:0] g0, g1, g2; logic [2:0] gm; logic ga;
    for (int it = 0; it < 6; it++) begin
      fmask = $urandom & 32'h00FF_FFFF;
      if (it % 3 == 0) fmask = '0;
      sweep(it % 2, 0, it >= 4, lat, nd, ok);
      g0 = (it % 2) ? tt0_b : tt0_a; g1 = (it % 2) ? tt1_b : tt1_a; g2 = (it % 2) ? tt2_b : tt2_a;
      gm = (it % 2) ? match_b : match_a; ga = (it % 2) ? agree_b : agree_a;
      checks++;
      if ({g0, g1, g2} !== {exp_tt(0, fmask), exp_tt(1, fmask), exp_tt(2, fmask)}) begin
        errs++; $display("FAIL rand_tt[%0d]: got %h/%h/%h want %h/%h/%h", it, g0, g1, g2,
                         exp_tt(0, fmask), exp_tt(1, fmask), exp_tt(2, fmask));
      end
      checks++;
      if (gm !== exp_match(fmask) || ga !== exp_agree(fmask) || nd !== 1 || !ok) begin
        errs++; $display("FAIL rand_flags[%0d]: got match=%b agree=%b n=%0d want %b/%b/1", it, gm, ga, nd,
                         exp_match(fmask), exp_agree(fmask));
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_fault();
    test_start_handling();
    test_mid_reset();
    test_settle0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
